// File: rtl/regfile_2w_sb.sv
// regfile_2w_sb: register file with two write ports and a pending-bit
// scoreboard for in-flight loads.
//
// Write port 0 carries ALU writeback and write port 1 carries load
// writeback. When both ports target the same register, port 1 wins.
//
// All state changes on the falling edge of clock. ctrl_reset_n is an
// asynchronous, active-low reset that clears the array and the scoreboard.
//
// Register 0 is hardwired: it reads as zero, ignores writes and is never
// marked pending.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write data
// (and the matching busy state) combinationally onto the read ports.
// Without it, reads and busy flags reflect stored state only.
module regfile_2w_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int SCORE_REG  = 1,
  parameter int STATUS_REG = 30
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable0,
  input  logic                  ctrl_writeEnable1,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg0,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg1,
  input  logic [DATA_WIDTH-1:0] data_writeReg0,
  input  logic [DATA_WIDTH-1:0] data_writeReg1,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_reserve,
  input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
  output logic                  data_busyA,
  output logic                  data_busyB,
  output logic [ADDR_WIDTH:0]   data_busyCount,
  output logic [DATA_WIDTH-1:0] data_score,
  output logic [DATA_WIDTH-1:0] data_rstatus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] SCORE_IDX  = SCORE_REG[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = STATUS_REG[ADDR_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pending_next;
  logic [ADDR_WIDTH:0]   busy_count;
  logic [ADDR_WIDTH:0]   count_next;

  logic wr0_ok;
  logic wr1_ok;
  logic res_ok;

  logic [DATA_WIDTH-1:0] read_a;
  logic [DATA_WIDTH-1:0] read_b;
  logic                  busy_a;
  logic                  busy_b;

  // A port only acts when enabled and aimed at a nonzero register.
  assign wr0_ok = ctrl_writeEnable0 && (ctrl_writeReg0 != '0);
  assign wr1_ok = ctrl_writeEnable1 && (ctrl_writeReg1 != '0);
  assign res_ok = ctrl_reserve && (ctrl_reserveReg != '0);

  // Next scoreboard: writes clear their destination, then a reserve sets its
  // target, so a same-edge reserve overrides a write's clear.
  always_comb begin
    pending_next = pending;
    if (wr0_ok) begin
      pending_next[ctrl_writeReg0] = 1'b0;
    end
    if (wr1_ok) begin
      pending_next[ctrl_writeReg1] = 1'b0;
    end
    if (res_ok) begin
      pending_next[ctrl_reserveReg] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Population count of the next scoreboard, registered with it so the count
  // always matches the stored bits.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_WIDTH{1'b0}}, pending_next[i]};
    end
  end

  // Register array update: port 1 is written last so it wins a shared
  // destination.
  always_ff @(negedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        regs[ctrl_writeReg0] <= data_writeReg0;
      end
      if (wr1_ok) begin
        regs[ctrl_writeReg1] <= data_writeReg1;
      end
    end
  end

  // Scoreboard bits and their count.
  always_ff @(negedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pending    <= '0;
      busy_count <= '0;
    end else begin
      pending    <= pending_next;
      busy_count <= count_next;
    end
  end

  // Read port A: stored value, optionally overridden by a same-edge write.
  always_comb begin
    read_a = regs[ctrl_readRegA];
    busy_a = pending[ctrl_readRegA];
`ifdef REGFILE_BYPASS_EN
    if (ctrl_reset_n) begin
      if (wr1_ok && (ctrl_writeReg1 == ctrl_readRegA)) begin
        read_a = data_writeReg1;
        busy_a = res_ok && (ctrl_reserveReg == ctrl_readRegA);
      end else if (wr0_ok && (ctrl_writeReg0 == ctrl_readRegA)) begin
        read_a = data_writeReg0;
        busy_a = res_ok && (ctrl_reserveReg == ctrl_readRegA);
      end
    end
`endif
    if (ctrl_readRegA == '0) begin
      read_a = '0;
      busy_a = 1'b0;
    end
  end

  // Read port B: same structure as port A.
  always_comb begin
    read_b = regs[ctrl_readRegB];
    busy_b = pending[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    if (ctrl_reset_n) begin
      if (wr1_ok && (ctrl_writeReg1 == ctrl_readRegB)) begin
        read_b = data_writeReg1;
        busy_b = res_ok && (ctrl_reserveReg == ctrl_readRegB);
      end else if (wr0_ok && (ctrl_writeReg0 == ctrl_readRegB)) begin
        read_b = data_writeReg0;
        busy_b = res_ok && (ctrl_reserveReg == ctrl_readRegB);
      end
    end
`endif
    if (ctrl_readRegB == '0) begin
      read_b = '0;
      busy_b = 1'b0;
    end
  end

  assign data_readRegA  = read_a;
  assign data_readRegB  = read_b;
  assign data_busyA     = busy_a;
  assign data_busyB     = busy_b;
  assign data_busyCount = busy_count;
  assign data_score     = regs[SCORE_IDX];
  assign data_rstatus   = regs[STATUS_IDX];

endmodule

// File: tb/tb_regfile_2w_sb.sv
// tb_regfile_2w_sb: directed scoreboard bench for regfile_2w_sb.
// Stimulus pushes expected output values for each cycle into a queue.
// A monitor pops and compares them at the rising edge, which lies midway
// between the falling edges that update the DUT.
// Expectations for the forwarding cases follow REGFILE_BYPASS_EN.
module tb_regfile_2w_sb;

  localparam int K_RA     = 0;
  localparam int K_RB     = 1;
  localparam int K_BA     = 2;
  localparam int K_BB     = 3;
  localparam int K_COUNT  = 4;
  localparam int K_SCORE  = 5;
  localparam int K_STATUS = 6;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        we0, we1;
  logic [4:0]  wr0, wr1;
  logic [31:0] d0, d1;
  logic [4:0]  ra, rb;
  logic [31:0] out_a, out_b;
  logic        res;
  logic [4:0]  res_reg;
  logic        busy_a, busy_b;
  logic [5:0]  busy_count;
  logic [31:0] score, rstatus;

  int          kind_q[$];
  logic [31:0] val_q[$];
  string       name_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;

  always #5 clock = ~clock;

  regfile_2w_sb dut (
    .clock             (clock),
    .ctrl_reset_n      (rst_n),
    .ctrl_writeEnable0 (we0),
    .ctrl_writeEnable1 (we1),
    .ctrl_writeReg0    (wr0),
    .ctrl_writeReg1    (wr1),
    .data_writeReg0    (d0),
    .data_writeReg1    (d1),
    .ctrl_readRegA     (ra),
    .ctrl_readRegB     (rb),
    .data_readRegA     (out_a),
    .data_readRegB     (out_b),
    .ctrl_reserve      (res),
    .ctrl_reserveReg   (res_reg),
    .data_busyA        (busy_a),
    .data_busyB        (busy_b),
    .data_busyCount    (busy_count),
    .data_score        (score),
    .data_rstatus      (rstatus)
  );

  task automatic apply_stimulus(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                                input logic rs, input logic [4:0] rsa,
                                input logic [4:0] a, input logic [4:0] b);
    we0 = w0e; wr0 = w0a; d0 = w0d;
    we1 = w1e; wr1 = w1a; d1 = w1d;
    res = rs;  res_reg = rsa;
    ra  = a;   rb = b;
  endtask

  task automatic check_output(input int kind, input logic [31:0] value, input string name);
    kind_q.push_back(kind);
    val_q.push_back(value);
    name_q.push_back(name);
    n_pushed++;
  endtask

  // Advance past the next falling edge so new inputs settle well before the
  // monitor samples at the following rising edge.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [31:0] get_actual(input int kind);
    case (kind)
      K_RA:     return out_a;
      K_RB:     return out_b;
      K_BA:     return {31'b0, busy_a};
      K_BB:     return {31'b0, busy_b};
      K_COUNT:  return {26'b0, busy_count};
      K_SCORE:  return score;
      K_STATUS: return rstatus;
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: every rising edge, compare all expectations queued this cycle.
  initial begin
    forever begin
      @(posedge clock);
      while (kind_q.size() > 0) begin
        int          k;
        logic [31:0] v;
        logic [31:0] act;
        string       nm;
        k   = kind_q.pop_front();
        v   = val_q.pop_front();
        nm  = name_q.pop_front();
        act = get_actual(k);
        n_checks++;
        if (act === v) begin
          n_pass++;
        end else begin
          $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", nm, act, v);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd30);
    #1;
    // Reset asserted with a write and a reserve presented: all outputs zero.
    rst_n = 1'b0;
    apply_stimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd30);
    check_output(K_RA, 32'h0, "rst_readA");
    check_output(K_BA, 32'h0, "rst_busyA");
    check_output(K_COUNT, 32'h0, "rst_count");
    check_output(K_SCORE, 32'h0, "rst_score");
    check_output(K_STATUS, 32'h0, "rst_status");
    tick();

    // Release reset between edges; the write and reserve seen during reset are gone.
    rst_n = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    check_output(K_RA, 32'h0, "discard_write");
    check_output(K_BA, 32'h0, "discard_reserve");
    check_output(K_COUNT, 32'h0, "discard_count");
    tick();

    // Port 0 writes r5.
    apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
`ifdef REGFILE_BYPASS_EN
    check_output(K_RA, 32'hDEAD_BEEF, "w0_fwd");
`else
    check_output(K_RA, 32'h0, "w0_pre_edge");
`endif
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    check_output(K_RA, 32'hDEAD_BEEF, "w0_r5");
    check_output(K_COUNT, 32'h0, "w0_count");
    tick();

    // Both ports write r7: port 1 wins.
    apply_stimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd0);
`ifdef REGFILE_BYPASS_EN
    check_output(K_RA, 32'h22, "dual_fwd_prio");
`else
    check_output(K_RA, 32'h0, "dual_pre_edge");
`endif
    tick();
    // Write to r0 is ignored, including on the forwarding path.
    apply_stimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    check_output(K_RA, 32'h22, "dual_p1_wins");
    check_output(K_RB, 32'h0, "r0_fwd");
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    check_output(K_RB, 32'h0, "r0_ignored");
    tick();

    // Reserve r3, r9, r3 again.
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9);
    check_output(K_BA, 32'h0, "res3_pre");
    check_output(K_COUNT, 32'h0, "res3_pre_count");
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3, 5'd9);
    check_output(K_BA, 32'h1, "res3_busy");
    check_output(K_COUNT, 32'h1, "res3_count");
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd9);
    check_output(K_BB, 32'h1, "res9_busy");
    check_output(K_COUNT, 32'h2, "res9_count");
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);
    check_output(K_COUNT, 32'h2, "rereserve_count");
    check_output(K_BA, 32'h1, "rereserve_busy");
    tick();

    // Port 1 (load) writes r3, clearing its pending bit.
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 5'd3, 5'd9);
`ifdef REGFILE_BYPASS_EN
    check_output(K_RA, 32'hAA, "ld3_fwd");
    check_output(K_BA, 32'h0, "ld3_fwd_busy");
`else
    check_output(K_RA, 32'h0, "ld3_pre");
    check_output(K_BA, 32'h1, "ld3_pre_busy");
`endif
    tick();
    apply_stimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);
    check_output(K_COUNT, 32'h1, "ld3_count");
    check_output(K_BA, 32'h0, "ld3_busy");
    check_output(K_RA, 32'hAA, "ld3_data");
`ifdef REGFILE_BYPASS_EN
    check_output(K_BB, 32'h0, "w9_fwd_busy");
`else
    check_output(K_BB, 32'h1, "w9_pre_busy");
`endif
    tick();

    // Reserve and write r4 on the same edge: reserve wins, data still lands.
    apply_stimulus(1'b1, 5'd4, 32'h5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd9);
    check_output(K_COUNT, 32'h0, "w9_count");
    check_output(K_BB, 32'h0, "w9_busy");
    check_output(K_RB, 32'h99, "w9_data");
`ifdef REGFILE_BYPASS_EN
    check_output(K_RA, 32'h5, "resw4_fwd");
    check_output(K_BA, 32'h1, "resw4_fwd_busy");
`else
    check_output(K_RA, 32'h0, "resw4_pre");
    check_output(K_BA, 32'h0, "resw4_pre_busy");
`endif
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    check_output(K_RA, 32'h5, "resw4_data");
    check_output(K_BA, 32'h1, "resw4_busy");
    check_output(K_COUNT, 32'h1, "resw4_count");
    tick();

    // Load the score and status taps, then pulse reset between edges.
    apply_stimulus(1'b1, 5'd1, 32'h64, 1'b1, 5'd30, 32'h1, 1'b0, 5'd0, 5'd4, 5'd9);
    check_output(K_SCORE, 32'h0, "score_pre");
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    check_output(K_SCORE, 32'h64, "score_tap");
    check_output(K_STATUS, 32'h1, "status_tap");
    check_output(K_COUNT, 32'h1, "tap_count");
    tick();
    rst_n = 1'b0;
    check_output(K_SCORE, 32'h0, "async_score");
    check_output(K_STATUS, 32'h0, "async_status");
    check_output(K_COUNT, 32'h0, "async_count");
    check_output(K_RA, 32'h0, "async_readA");
    check_output(K_BA, 32'h0, "async_busyA");
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd4);
    check_output(K_RB, 32'h0, "post_rst_data");
    check_output(K_SCORE, 32'h0, "post_rst_score");
    check_output(K_COUNT, 32'h0, "post_rst_count");
    tick();

    // Reserving r0 has no effect.
    apply_stimulus(1'b1, 5'd6, 32'h123, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd6);
    check_output(K_COUNT, 32'h0, "res0_count");
    check_output(K_BA, 32'h0, "res0_busy");
    tick();

    // Port 1 writes r6 while read port B watches it.
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hABC, 1'b0, 5'd0, 5'd0, 5'd6);
`ifdef REGFILE_BYPASS_EN
    check_output(K_RB, 32'hABC, "r6_fwd");
`else
    check_output(K_RB, 32'h123, "r6_old");
`endif
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd6);
    check_output(K_RB, 32'hABC, "r6_new");
    tick();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && kind_q.size() > 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (n_checks != n_pushed) begin
      $display("[TB] FAIL drain: got %0d checks, want %0d", n_checks, n_pushed);
      n_checks = n_pushed + 1;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_2w_sb.md
REGFILE_2W_SB -- requirements
Module: regfile_2w_sb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 Parameter SCORE_REG, default 1, index driven onto data_score.
REQ-004 Parameter STATUS_REG, default 30, index driven onto data_rstatus.
REQ-005 clock  in  1  single clock; all state updates on its falling edge.
REQ-006 ctrl_reset_n  in  1  asynchronous, active-low reset.
REQ-007 ctrl_writeEnable0 / ctrl_writeEnable1  in  1 each  write-port enables; port 0 is ALU writeback, port 1 is load writeback.
REQ-008 ctrl_writeReg0 / ctrl_writeReg1  in  ADDR_WIDTH each  write destinations.
REQ-009 data_writeReg0 / data_writeReg1  in  DATA_WIDTH each  write data.
REQ-010 ctrl_readRegA / ctrl_readRegB  in  ADDR_WIDTH each  read addresses.
REQ-011 data_readRegA / data_readRegB  out  DATA_WIDTH each  read data.
REQ-012 ctrl_reserve  in  1  marks ctrl_reserveReg pending, for example on load issue.
REQ-013 ctrl_reserveReg  in  ADDR_WIDTH  register to mark pending.
REQ-014 data_busyA / data_busyB  out  1 each  pending bit of ctrl_readRegA / ctrl_readRegB.
REQ-015 data_busyCount  out  ADDR_WIDTH+1  number of pending registers.
REQ-016 data_score / data_rstatus  out  DATA_WIDTH each  continuous taps of SCORE_REG / STATUS_REG.

Function
REQ-017 Register 0 SHALL read as 0, ignore all writes, and never become pending.
REQ-018 On a clock falling edge with a write enable high and a nonzero destination, the enabled port SHALL write its destination.
REQ-019 If both ports write the same nonzero register on one edge, port 1 data SHALL be stored.
REQ-020 Reads SHALL be combinational from the stored array, with zero-cycle latency, unless REQ-030 applies.
REQ-021 On a falling edge with ctrl_reserve high and ctrl_reserveReg nonzero, the pending bit of ctrl_reserveReg SHALL be set.
REQ-022 An enabled write by either port SHALL clear the pending bit of its destination on the same edge.
REQ-023 If a reserve and a write target the same register on one edge, the reserve SHALL win: the bit stays set and the data is still written.
REQ-024 Reserving an already-pending register SHALL leave its bit set and SHALL NOT change data_busyCount.
REQ-025 A write to a non-pending register SHALL leave its bit clear.
REQ-026 data_busyCount SHALL equal the population count of the pending bits after every edge and SHALL never exceed 2**ADDR_WIDTH-1.
REQ-027 data_busyA and data_busyB SHALL be combinational from the stored pending bits and SHALL be 0 for index 0.

Reset
REQ-028 While ctrl_reset_n is low, all registers and all pending bits SHALL be 0, independent of clock. Consequently all data outputs, busy outputs and data_busyCount read 0.
REQ-029 Writes and reserves presented on an edge while ctrl_reset_n is low SHALL be discarded. The first edge after deassertion SHALL operate normally.

Configuration
REQ-030 With REGFILE_BYPASS_EN defined:
- a read whose address matches an enabled nonzero write destination SHALL return that write data combinationally, port 1 taking priority over port 0;
- data_busyA/B SHALL return 0 for that address unless a same-edge reserve targets it.
REQ-031 Without REGFILE_BYPASS_EN:
- reads SHALL return stored values only, so write data becomes visible after the falling edge;
- busy outputs SHALL reflect stored bits only.

Verification
REQ-032 Release reset, write 0xDEADBEEF to r5 via port 0 on one falling edge, then read A=5 -> data_readRegA=0xDEADBEEF; data_busyCount=0.
REQ-033 Both ports write r7 on one edge, port 0=0x11 and port 1=0x22 -> r7 reads 0x22; write r0=0xFFFF -> r0 reads 0.
REQ-034 Reserve r3, then r9, then r3 again -> data_busyCount=2, data_busyA=1 for readRegA=3. Port 1 writes r3 -> count=1, busyA=0.
REQ-035 Reserve r4 and port 0 write r4=0x5 on the same edge -> r4 reads 0x5, busy stays 1, count=1.
REQ-036 With r1=0x64 and r30=0x1 written, pulse ctrl_reset_n low between edges -> data_score, data_rstatus, data_busyCount all 0 immediately, before the next edge.
REQ-037 With REGFILE_BYPASS_EN defined, present a port 1 write r6=0xABC with readRegB=6 before the edge -> data_readRegB=0xABC. Undefined -> old r6 value until after the edge.
